booth_mult_seq: RTL and testbench

//  Iterative radix-4 Booth multiplier for the arithmetic unit: one Booth digit retired per clock.

---
 rtl/booth_pkg.sv | 32 +++
 rtl/booth_digit_sel.sv | 37 +++
 rtl/booth_mult_seq.sv | 131 +++++++++++++
 tb/tb_booth_mult_seq.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/booth_pkg.sv
// Shared types for the radix-4 Booth multiplier: FSM states, Booth digit encoding
// and the triplet-to-digit recoder.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  typedef enum logic [2:0] {
    ZERO = 3'b000,
    P1   = 3'b001,
    P2   = 3'b010,
    M1   = 3'b101,
    M2   = 3'b110
  } digit_t;

  // Triplet is {b[2i+1], b[2i], b[2i-1]}.
  function automatic digit_t booth_recode(input logic [2:0] triplet);
    digit_t d;
    case (triplet)
      3'b001, 3'b010: d = P1;
      3'b011:         d = P2;
      3'b100:         d = M2;
      3'b101, 3'b110: d = M1;
      default:        d = ZERO;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/booth_digit_sel.sv
// Booth digit selector: turns a recoded triplet and the extended multiplicand into
// the addend for the partial-product adder plus its carry-in (negation as ~x + 1).
module booth_digit_sel #(
  parameter int WIDTH = 8
) (
  input  logic [2:0]              triplet,
  input  logic signed [WIDTH+1:0] a_ext,
  output logic signed [WIDTH+1:0] addend,
  output logic                    carry_in
);
  import booth_pkg::*;

  digit_t                  digit;
  logic signed [WIDTH+1:0] a_x2;

  assign digit = booth_recode(triplet);
  assign a_x2  = a_ext <<< 1;

  always_comb begin
    addend   = '0;
    carry_in = 1'b0;
    case (digit)
      P1: addend = a_ext;
      P2: addend = a_x2;
      M1: begin
        addend   = ~a_ext;
        carry_in = 1'b1;
      end
      M2: begin
        addend   = ~a_x2;
        carry_in = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/booth_mult_seq.sv
// Iterative radix-4 Booth multiplier, one digit per clock, valid/ready on both sides.
// Define BOOTH_UNSIGNED_EN to add the tc input (1=signed, 0=unsigned operands).
module booth_mult_seq #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WIDTH-1:0]     A,
  input  logic [WIDTH-1:0]     B,
`ifdef BOOTH_UNSIGNED_EN
  input  logic                 tc,
`endif
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [2*WIDTH-1:0]   result
);
  import booth_pkg::*;

  localparam int NS = WIDTH / 2;
  localparam int CW = $clog2(WIDTH / 2 + 2);
  localparam int PW = 2 * WIDTH + 3;

  state_t                  state_q, state_d;
  logic [CW-1:0]           cnt;
  logic [PW-1:0]           p;
  logic signed [WIDTH+1:0] a_ext;
  logic                    uns;
  logic                    sign_a;
  logic                    accept;
  logic                    last_step;
  logic                    fix_step;
  logic [2:0]              triplet;
  logic signed [WIDTH+1:0] addend;
  logic                    carry_in;
  logic [WIDTH+1:0]        p_hi;
  logic [WIDTH+1:0]        sum;
  logic [PW-1:0]           p_sum;
  logic [PW-1:0]           p_next;

`ifdef BOOTH_UNSIGNED_EN
  assign sign_a = tc & A[WIDTH-1];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      uns <= 1'b0;
    end else if (accept) begin
      uns <= ~tc;
    end
  end
`else
  assign sign_a = A[WIDTH-1];
  assign uns    = 1'b0;
`endif

  assign accept = in_valid && in_ready;

  // Unsigned mode appends one step that adds b[W-1]*A*2^W without shifting,
  // turning the signed interpretation of B into the unsigned one.
  assign fix_step  = uns && (cnt == CW'(NS));
  assign last_step = uns ? fix_step : (cnt == CW'(NS - 1));
  assign triplet   = fix_step ? {2'b00, p[0]} : p[2:0];

  booth_digit_sel #(.WIDTH(WIDTH)) u_digit_sel (
    .triplet  (triplet),
    .a_ext    (a_ext),
    .addend   (addend),
    .carry_in (carry_in)
  );

  assign p_hi   = p[PW-1 -: WIDTH+2];
  assign sum    = p_hi + addend + {{(WIDTH+1){1'b0}}, carry_in};
  assign p_sum  = {sum, p[WIDTH:0]};
  assign p_next = fix_step ? p_sum : {{2{p_sum[PW-1]}}, p_sum[PW-1:2]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    case (state_q)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_d = CALC;
      end
      CALC: begin
        if (last_step) state_d = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Datapath: operand load on accept, one Booth digit per CALC cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      p      <= '0;
      a_ext  <= '0;
      cnt    <= '0;
      result <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept) begin
            a_ext <= {sign_a, sign_a, A};
            p     <= {{(WIDTH+2){1'b0}}, B, 1'b0};
            cnt   <= '0;
          end
        end
        CALC: begin
          p   <= p_next;
          cnt <= cnt + CW'(1);
          if (last_step) result <= p_next[2*WIDTH:1];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_booth_mult_seq.sv
// Directed and randomised bench for booth_mult_seq at WIDTH=8 and WIDTH=16,
// with back-pressure and mid-operation reset; tc cases when BOOTH_UNSIGNED_EN is set.
module tb_booth_mult_seq;

  logic        clk, rst;
  logic        iv8, ir8, ov8, ordy8;
  logic [7:0]  a8, b8;
  logic [15:0] r8;
  logic        iv16, ir16, ov16, ordy16;
  logic [15:0] a16, b16;
  logic [31:0] r16;
`ifdef BOOTH_UNSIGNED_EN
  logic        tc;
`endif

  int tests = 0;
  int fails = 0;

  booth_mult_seq #(.WIDTH(8)) dut8 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv8),
    .in_ready  (ir8),
    .A         (a8),
    .B         (b8),
`ifdef BOOTH_UNSIGNED_EN
    .tc        (tc),
`endif
    .out_valid (ov8),
    .out_ready (ordy8),
    .result    (r8)
  );

  booth_mult_seq #(.WIDTH(16)) dut16 (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (iv16),
    .in_ready  (ir16),
    .A         (a16),
    .B         (b16),
`ifdef BOOTH_UNSIGNED_EN
    .tc        (1'b1),
`endif
    .out_valid (ov16),
    .out_ready (ordy16),
    .result    (r16)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit w16, input logic v, input logic [15:0] a, input logic [15:0] b);
    if (w16) begin
      iv16 = v; a16 = a; b16 = b;
    end else begin
      iv8 = v; a8 = a[7:0]; b8 = b[7:0];
    end
  endtask

  task automatic set_ordy(input bit w16, input logic v);
    if (w16) ordy16 = v;
    else     ordy8  = v;
  endtask

  function automatic logic get_ov(input bit w16);
    return w16 ? ov16 : ov8;
  endfunction

  function automatic logic get_ir(input bit w16);
    return w16 ? ir16 : ir8;
  endfunction

  function automatic logic [31:0] get_res(input bit w16);
    return w16 ? r16 : {16'h0000, r8};
  endfunction

  task automatic op(input bit w16, input logic [15:0] a, input logic [15:0] b,
                    input logic [31:0] exp, input int explat, input int stall, input string tag);
    int lat;
    drive(w16, 1'b1, a, b);
    check({tag, "_in_ready"}, {31'b0, get_ir(w16)}, 32'd1);
    tick();
    drive(w16, 1'b0, a, b);
    lat = 0;
    while (!get_ov(w16) && lat < 40) begin
      tick();
      lat++;
    end
    check({tag, "_latency"}, lat, explat);
    check({tag, "_result"}, get_res(w16), exp);
    for (int i = 0; i < stall; i++) begin
      drive(w16, 1'b1, ~a, b);
      tick();
      check({tag, "_hold_valid"}, {31'b0, get_ov(w16)}, 32'd1);
      check({tag, "_hold_result"}, get_res(w16), exp);
      check({tag, "_hold_in_ready"}, {31'b0, get_ir(w16)}, 32'd0);
    end
    drive(w16, 1'b0, a, b);
    set_ordy(w16, 1'b1);
    tick();
    set_ordy(w16, 1'b0);
    check({tag, "_post_valid"}, {31'b0, get_ov(w16)}, 32'd0);
    check({tag, "_post_in_ready"}, {31'b0, get_ir(w16)}, 32'd1);
  endtask

  initial begin
    logic signed [7:0]  x8, y8;
    logic signed [15:0] p8;
    logic signed [15:0] x16, y16;
    logic signed [31:0] p16;
    int                 seen;

    rst = 1'b1;
    iv8 = 1'b0; a8 = '0; b8 = '0; ordy8 = 1'b0;
    iv16 = 1'b0; a16 = '0; b16 = '0; ordy16 = 1'b0;
`ifdef BOOTH_UNSIGNED_EN
    tc = 1'b1;
`endif
    #1;
    check("reset_in_ready", {31'b0, ir8}, 32'd1);
    check("reset_out_valid", {31'b0, ov8}, 32'd0);
    check("reset_result8", {16'h0, r8}, 32'd0);
    check("reset_result16", r16, 32'd0);
    tick();
    tick();
    rst = 1'b0;
    tick();

    op(1'b0, 16'd7,    16'd3,    32'h0000_0015, 4, 0, "mul_7x3");
    op(1'b0, 16'h0080, 16'h0080, 32'h0000_4000, 4, 0, "mul_min_min");
    op(1'b0, 16'h0080, 16'h007F, 32'h0000_C080, 4, 0, "mul_min_max");
    op(1'b0, 16'h0000, 16'h00FF, 32'h0000_0000, 4, 0, "mul_0xm1");
    op(1'b0, 16'h00FD, 16'h0009, 32'h0000_FFE5, 4, 5, "backpressure");

    // Reset in the second CALC cycle must discard the operation.
    drive(1'b0, 1'b1, 16'd7, 16'd3);
    tick();
    drive(1'b0, 1'b0, 16'd7, 16'd3);
    tick();
    rst = 1'b1;
    #1;
    check("midreset_in_ready", {31'b0, ir8}, 32'd1);
    check("midreset_out_valid", {31'b0, ov8}, 32'd0);
    check("midreset_result", {16'h0, r8}, 32'd0);
    tick();
    rst = 1'b0;
    seen = 0;
    for (int i = 0; i < 6; i++) begin
      tick();
      if (ov8) seen++;
    end
    check("midreset_no_valid", seen, 0);
    op(1'b0, 16'h0005, 16'h00FA, 32'h0000_FFE2, 4, 0, "after_reset");

    op(1'b1, 16'h8000, 16'h8000, 32'h4000_0000, 8, 0, "w16_min_min");
    op(1'b1, 16'h1234, 16'hFFFF, 32'hFFFF_EDCC, 8, 2, "w16_neg");

`ifdef BOOTH_UNSIGNED_EN
    tc = 1'b0;
    op(1'b0, 16'h00FF, 16'h00FF, 32'h0000_FE01, 5, 0, "unsigned_255sq");
    tc = 1'b1;
    op(1'b0, 16'h00FF, 16'h00FF, 32'h0000_0001, 4, 0, "signed_m1sq");
`endif

    for (int i = 0; i < 6; i++) begin
      x8 = 8'($urandom);
      y8 = 8'($urandom);
      p8 = x8 * y8;
      op(1'b0, {8'h00, x8}, {8'h00, y8}, {16'h0000, p8}, 4, $urandom_range(0, 3), "rnd8");
    end
    for (int i = 0; i < 6; i++) begin
      x16 = 16'($urandom);
      y16 = 16'($urandom);
      p16 = x16 * y16;
      op(1'b1, x16, y16, p16, 8, $urandom_range(0, 3), "rnd16");
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
